// File: rtl/regfile_arbiter_if.sv
// Request/response and register-file bus between the two requesters, the
// shared register file and the arbiter.
interface regfile_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   // requester 0 (core datapath)
   logic              i_req_valid_0;
   logic              o_req_ready_0;
   logic              i_req_we_0;
   logic [ADDR_W-1:0] i_req_addr0_0;
   logic [ADDR_W-1:0] i_req_addr1_0;
   logic [DATA_W-1:0] i_req_wdata_0;
   logic              o_rsp_valid_0;
   logic              i_rsp_ready_0;
   logic [DATA_W-1:0] o_rsp_data0_0;
   logic [DATA_W-1:0] o_rsp_data1_0;
   // requester 1 (debug/load port)
   logic              i_req_valid_1;
   logic              o_req_ready_1;
   logic              i_req_we_1;
   logic [ADDR_W-1:0] i_req_addr0_1;
   logic [ADDR_W-1:0] i_req_addr1_1;
   logic [DATA_W-1:0] i_req_wdata_1;
   logic              o_rsp_valid_1;
   logic              i_rsp_ready_1;
   logic [DATA_W-1:0] o_rsp_data0_1;
   logic [DATA_W-1:0] o_rsp_data1_1;
   // register file side
   logic              o_rf_we;
   logic [ADDR_W-1:0] o_rf_addr0;
   logic [ADDR_W-1:0] o_rf_addr1;
   logic [DATA_W-1:0] o_rf_wdata;
   logic [DATA_W-1:0] i_rf_data0;
   logic [DATA_W-1:0] i_rf_data1;

   // arbiter view
   modport slave (
      input  i_req_valid_0, i_req_we_0, i_req_addr0_0, i_req_addr1_0, i_req_wdata_0, i_rsp_ready_0,
      output o_req_ready_0, o_rsp_valid_0, o_rsp_data0_0, o_rsp_data1_0,
      input  i_req_valid_1, i_req_we_1, i_req_addr0_1, i_req_addr1_1, i_req_wdata_1, i_rsp_ready_1,
      output o_req_ready_1, o_rsp_valid_1, o_rsp_data0_1, o_rsp_data1_1,
      output o_rf_we, o_rf_addr0, o_rf_addr1, o_rf_wdata,
      input  i_rf_data0, i_rf_data1
   );

   // requester + register file view
   modport master (
      output i_req_valid_0, i_req_we_0, i_req_addr0_0, i_req_addr1_0, i_req_wdata_0, i_rsp_ready_0,
      input  o_req_ready_0, o_rsp_valid_0, o_rsp_data0_0, o_rsp_data1_0,
      output i_req_valid_1, i_req_we_1, i_req_addr0_1, i_req_addr1_1, i_req_wdata_1, i_rsp_ready_1,
      input  o_req_ready_1, o_rsp_valid_1, o_rsp_data0_1, o_rsp_data1_1,
      input  o_rf_we, o_rf_addr0, o_rf_addr1, o_rf_wdata,
      output i_rf_data0, i_rf_data1
   );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin two-requester arbiter for a single-access register file with a
// one-entry response buffer per requester. Grant and register-file drive are
// combinational in the request cycle; responses appear one cycle later.
module regfile_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input logic             i_clk,
   input logic             i_rst_n,
   regfile_arbiter_if.slave bus
);

   logic elig_0;
   logic elig_1;
   logic grant_0;
   logic grant_1;
   logic last_q;   // requester granted most recently

   // Eligibility and round-robin grant; reset gates grants so the bus idles.
   always_comb begin
      elig_0  = i_rst_n && bus.i_req_valid_0 && (!bus.o_rsp_valid_0 || bus.i_rsp_ready_0);
      elig_1  = i_rst_n && bus.i_req_valid_1 && (!bus.o_rsp_valid_1 || bus.i_rsp_ready_1);
      grant_0 = elig_0 && (!elig_1 || last_q);
      grant_1 = elig_1 && (!elig_0 || !last_q);
      bus.o_req_ready_0 = grant_0;
      bus.o_req_ready_1 = grant_1;
   end

   // Register-file drive from the granted request, idle zeros otherwise.
   always_comb begin
      bus.o_rf_we    = 1'b0;
      bus.o_rf_addr0 = '0;
      bus.o_rf_addr1 = '0;
      bus.o_rf_wdata = '0;
      if (grant_0) begin
         bus.o_rf_we    = bus.i_req_we_0;
         bus.o_rf_addr0 = bus.i_req_addr0_0;
         bus.o_rf_addr1 = bus.i_req_addr1_0;
         bus.o_rf_wdata = bus.i_req_wdata_0;
      end else if (grant_1) begin
         bus.o_rf_we    = bus.i_req_we_1;
         bus.o_rf_addr0 = bus.i_req_addr0_1;
         bus.o_rf_addr1 = bus.i_req_addr1_1;
         bus.o_rf_wdata = bus.i_req_wdata_1;
      end
   end

   // Last-grant pointer; starts at 1 so requester 0 wins the first tie.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_q <= 1'b1;
      end else if (grant_0) begin
         last_q <= 1'b0;
      end else if (grant_1) begin
         last_q <= 1'b1;
      end
   end

   // Requester 0 response buffer: read data, or zeros as a write ack.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bus.o_rsp_valid_0 <= 1'b0;
         bus.o_rsp_data0_0 <= '0;
         bus.o_rsp_data1_0 <= '0;
      end else if (grant_0) begin
         bus.o_rsp_valid_0 <= 1'b1;
         bus.o_rsp_data0_0 <= bus.i_req_we_0 ? '0 : bus.i_rf_data0;
         bus.o_rsp_data1_0 <= bus.i_req_we_0 ? '0 : bus.i_rf_data1;
      end else if (bus.i_rsp_ready_0) begin
         bus.o_rsp_valid_0 <= 1'b0;
      end
   end

   // Requester 1 response buffer: read data, or zeros as a write ack.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bus.o_rsp_valid_1 <= 1'b0;
         bus.o_rsp_data0_1 <= '0;
         bus.o_rsp_data1_1 <= '0;
      end else if (grant_1) begin
         bus.o_rsp_valid_1 <= 1'b1;
         bus.o_rsp_data0_1 <= bus.i_req_we_1 ? '0 : bus.i_rf_data0;
         bus.o_rsp_data1_1 <= bus.i_req_we_1 ? '0 : bus.i_rf_data1;
      end else if (bus.i_rsp_ready_1) begin
         bus.o_rsp_valid_1 <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the arbiter and register file.
module tb_regfile_arbiter;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NREG   = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // requester stimulus
   logic              req_v   [2];
   logic              req_we  [2];
   logic [ADDR_W-1:0] req_a0  [2];
   logic [ADDR_W-1:0] req_a1  [2];
   logic [DATA_W-1:0] req_wd  [2];
   logic              rsp_rdy [2];

   assign bus.i_req_valid_0 = req_v[0];
   assign bus.i_req_we_0    = req_we[0];
   assign bus.i_req_addr0_0 = req_a0[0];
   assign bus.i_req_addr1_0 = req_a1[0];
   assign bus.i_req_wdata_0 = req_wd[0];
   assign bus.i_rsp_ready_0 = rsp_rdy[0];
   assign bus.i_req_valid_1 = req_v[1];
   assign bus.i_req_we_1    = req_we[1];
   assign bus.i_req_addr0_1 = req_a0[1];
   assign bus.i_req_addr1_1 = req_a1[1];
   assign bus.i_req_wdata_1 = req_wd[1];
   assign bus.i_rsp_ready_1 = rsp_rdy[1];

   // register file driven only by the DUT's outputs
   logic [DATA_W-1:0] rf_mem [NREG];
   always @(posedge clk) if (bus.o_rf_we) rf_mem[bus.o_rf_addr0] <= bus.o_rf_wdata;
   assign bus.i_rf_data0 = rf_mem[bus.o_rf_addr0];
   assign bus.i_rf_data1 = rf_mem[bus.o_rf_addr1];

   // DUT outputs gathered per requester
   logic              a_ready [2];
   logic              a_rv    [2];
   logic [DATA_W-1:0] a_d0    [2];
   logic [DATA_W-1:0] a_d1    [2];
   assign a_ready[0] = bus.o_req_ready_0;
   assign a_ready[1] = bus.o_req_ready_1;
   assign a_rv[0]    = bus.o_rsp_valid_0;
   assign a_rv[1]    = bus.o_rsp_valid_1;
   assign a_d0[0]    = bus.o_rsp_data0_0;
   assign a_d0[1]    = bus.o_rsp_data0_1;
   assign a_d1[0]    = bus.o_rsp_data1_0;
   assign a_d1[1]    = bus.o_rsp_data1_1;

   // transaction-level model
   logic              m_valid [2];
   logic [DATA_W-1:0] m_d0    [2];
   logic [DATA_W-1:0] m_d1    [2];
   logic [DATA_W-1:0] m_mem   [NREG];
   int                m_last;
   int                last_w;   // winner of the most recent step, -1 = none

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin
         m_valid[n] = 1'b0;
         m_d0[n] = '0;
         m_d1[n] = '0;
      end
      m_last = 1;
   endtask

   task automatic set_req(input int n, input logic v, input logic we, input int a0, input int a1,
                          input logic [DATA_W-1:0] wd);
      req_v[n]  = v;
      req_we[n] = we;
      req_a0[n] = ADDR_W'(a0);
      req_a1[n] = ADDR_W'(a1);
      req_wd[n] = wd;
   endtask

   // One clock cycle: inputs are already set; compare the request-cycle
   // outputs, advance the model, then compare the response buffers.
   task automatic step();
      logic e [2];
      int   w;
      logic             x_we;
      logic [ADDR_W-1:0] x_a0, x_a1;
      logic [DATA_W-1:0] x_wd;
      #1;
      for (int n = 0; n < 2; n++) e[n] = rst_n && req_v[n] && (!m_valid[n] || rsp_rdy[n]);
      if (e[0] && e[1]) w = 1 - m_last;
      else if (e[0]) w = 0;
      else if (e[1]) w = 1;
      else w = -1;
      x_we = 1'b0; x_a0 = '0; x_a1 = '0; x_wd = '0;
      if (w >= 0) begin
         x_we = req_we[w]; x_a0 = req_a0[w]; x_a1 = req_a1[w]; x_wd = req_wd[w];
      end
      check("ready_0", 32'(a_ready[0]), 32'(w == 0));
      check("ready_1", 32'(a_ready[1]), 32'(w == 1));
      check("rf_we",    32'(bus.o_rf_we),    32'(x_we));
      check("rf_addr0", 32'(bus.o_rf_addr0), 32'(x_a0));
      check("rf_addr1", 32'(bus.o_rf_addr1), 32'(x_a1));
      check("rf_wdata", bus.o_rf_wdata, x_wd);
      for (int n = 0; n < 2; n++) begin
         if (w == n) begin
            m_valid[n] = 1'b1;
            m_d0[n] = req_we[n] ? '0 : m_mem[req_a0[n]];
            m_d1[n] = req_we[n] ? '0 : m_mem[req_a1[n]];
         end else if (rsp_rdy[n]) begin
            m_valid[n] = 1'b0;
         end
      end
      if (w >= 0) begin
         if (req_we[w]) m_mem[req_a0[w]] = req_wd[w];
         m_last = w;
      end
      last_w = w;
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
         check($sformatf("rsp_valid_%0d", n), 32'(a_rv[n]), 32'(m_valid[n]));
         if (m_valid[n]) begin
            check($sformatf("rsp_data0_%0d", n), a_d0[n], m_d0[n]);
            check($sformatf("rsp_data1_%0d", n), a_d1[n], m_d1[n]);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [DATA_W-1:0] held;
      int order [6];
      for (int i = 0; i < int'(NREG); i++) begin
         rf_mem[i] = '0;
         m_mem[i]  = '0;
      end
      for (int n = 0; n < 2; n++) begin
         set_req(n, 1'b0, 1'b0, 0, 0, '0);
         rsp_rdy[n] = 1'b1;
      end
      model_reset();
      last_w = -1;
      repeat (3) @(negedge clk);
      // reset values
      for (int n = 0; n < 2; n++) begin
         check("reset rsp_valid", 32'(a_rv[n]), 32'd0);
         check("reset rsp_data0", a_d0[n], 32'd0);
         check("reset rsp_data1", a_d1[n], 32'd0);
         check("reset ready", 32'(a_ready[n]), 32'd0);
      end
      check("reset rf_we", 32'(bus.o_rf_we), 32'd0);
      rst_n = 1'b1;

      // requester 0 writes 5 = DEADBEEF, then reads (5,0)
      set_req(0, 1'b1, 1'b1, 5, 9, 32'hDEADBEEF);
      #1;
      check("wr ready_0", 32'(a_ready[0]), 32'd1);
      check("wr rf_we", 32'(bus.o_rf_we), 32'd1);
      check("wr rf_addr0", 32'(bus.o_rf_addr0), 32'd5);
      step();
      check("wr ack valid", 32'(a_rv[0]), 32'd1);
      check("wr ack data0", a_d0[0], 32'd0);
      set_req(0, 1'b1, 1'b0, 5, 0, '0);
      step();
      check("rd data0", a_d0[0], 32'hDEADBEEF);
      check("rd data1", a_d1[0], 32'd0);

      // requester 1 alone, so requester 0 wins the next tie
      set_req(0, 1'b0, 1'b0, 0, 0, '0);
      set_req(1, 1'b1, 1'b0, 1, 2, '0);
      step();
      // both read continuously: grants alternate 0,1,0,1,0,1
      for (int i = 0; i < 6; i++) begin
         set_req(0, 1'b1, 1'b0, i, 5, '0);
         set_req(1, 1'b1, 1'b0, 5, i + 1, '0);
         step();
         order[i] = last_w;
         check("alt rsp_valid", 32'(a_rv[i % 2]), 32'd1);
      end
      for (int i = 0; i < 6; i++) check("alt order", 32'(order[i]), 32'(i % 2));

      // requester 1 stalls its response; requester 0 gets every cycle
      rsp_rdy[1] = 1'b0;
      held = a_d0[1];
      for (int i = 0; i < 4; i++) begin
         set_req(0, 1'b1, 1'b0, i, i, '0);
         set_req(1, 1'b1, 1'b0, 7, 7, '0);
         step();
         check("stall grant0", 32'(last_w), 32'd0);
         check("stall data held", a_d0[1], held);
      end
      rsp_rdy[1] = 1'b1;
      #1;
      check("unstall ready_1", 32'(a_ready[1]), 32'd1);
      step();

      // read-after-write across requesters
      set_req(0, 1'b0, 1'b0, 0, 0, '0);
      set_req(1, 1'b1, 1'b1, 3, 0, 32'h12345678);
      step();
      set_req(1, 1'b0, 1'b0, 0, 0, '0);
      set_req(0, 1'b1, 1'b0, 3, 3, '0);
      step();
      check("raw data0", a_d0[0], 32'h12345678);
      check("raw data1", a_d1[0], 32'h12345678);

      // randomized traffic; requests stay stable until granted
      set_req(0, 1'b0, 1'b0, 0, 0, '0);
      for (int c = 0; c < 3000; c++) begin
         for (int n = 0; n < 2; n++) begin
            if (!req_v[n] || last_w == n) begin
               if ($urandom_range(3) != 0)
                  set_req(n, 1'b1, 1'($urandom_range(1)), int'($urandom_range(7)),
                          int'($urandom_range(31)), $urandom);
               else
                  set_req(n, 1'b0, 1'b0, 0, 0, '0);
            end
            rsp_rdy[n] = ($urandom_range(3) != 0);
         end
         step();
      end

      // asynchronous reset while requester 0 holds a response and 1 is granted
      set_req(0, 1'b1, 1'b0, 4, 4, '0);
      set_req(1, 1'b0, 1'b0, 0, 0, '0);
      rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
      step();
      rsp_rdy[0] = 1'b0;
      set_req(0, 1'b0, 1'b0, 0, 0, '0);
      set_req(1, 1'b1, 1'b0, 7, 6, '0);
      #1;
      check("pre-rst ready_1", 32'(a_ready[1]), 32'd1);
      check("pre-rst rsp_valid_0", 32'(a_rv[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst rsp_valid_0", 32'(a_rv[0]), 32'd0);
      check("rst rsp_data0_0", a_d0[0], 32'd0);
      check("rst ready_1", 32'(a_ready[1]), 32'd0);
      check("rst rf_addr0", 32'(bus.o_rf_addr0), 32'd0);
      check("rst rf_addr1", 32'(bus.o_rf_addr1), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 1, 2, '0);
      set_req(1, 1'b1, 1'b0, 3, 4, '0);
      rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
      rst_n = 1'b1;
      #1;
      check("post-rst tie ready_0", 32'(a_ready[0]), 32'd1);
      check("post-rst tie ready_1", 32'(a_ready[1]), 32'd0);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester arbiter that shares the single-access register file between the core datapath (requester 0) and the debug/load port (requester 1). It grants at most one access per cycle, round-robin on contention, and drives the register file's write-enable, address and write-data inputs. It captures read data into a one-entry response buffer per requester and returns it with a valid/ready handshake.

## Interface
- DATA_W, 32, data width of register file and all data ports
- ADDR_W, 5, register address width (32 entries)

- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_req_valid_0 / i_req_valid_1  input  1  request valid, held stable until accepted
- o_req_ready_0 / o_req_ready_1  output  1  request accepted this cycle (grant)
- i_req_we_0 / i_req_we_1  input  1  1 = write, 0 = read
- i_req_addr0_0 / i_req_addr0_1  input  ADDR_W  write address, or first read address
- i_req_addr1_0 / i_req_addr1_1  input  ADDR_W  second read address; ignored on write
- i_req_wdata_0 / i_req_wdata_1  input  DATA_W  write data
- o_rsp_valid_0 / o_rsp_valid_1  output  1  response valid
- i_rsp_ready_0 / i_rsp_ready_1  input  1  response consumed
- o_rsp_data0_0 / o_rsp_data0_1  output  DATA_W  read data for addr0; 0 for write acks
- o_rsp_data1_0 / o_rsp_data1_1  output  DATA_W  read data for addr1; 0 for write acks
- o_rf_we  output  1  register file write enable
- o_rf_addr0, o_rf_addr1  output  ADDR_W  register file addresses
- o_rf_wdata  output  DATA_W  register file write data
- i_rf_data0, i_rf_data1  input  DATA_W  register file combinational read data (valid only when o_rf_we=0)

## Operation
- Eligibility: elig_n = i_req_valid_n && (!o_rsp_valid_n || i_rsp_ready_n). A response being consumed in the same cycle frees its slot.
- Arbitration: if only one requester is eligible, it is granted. If both are eligible, the one not granted last is granted. The last-grant pointer updates only on a grant. Its reset value is 1, so requester 0 wins the first tie.
- o_req_ready_n = grant_n. This is combinational from valid, and at most one grant is active per cycle.
- Register file drive (combinational, from the granted request):
  - we = req_we
  - addr0 = req_addr0
  - addr1 = req_addr1
  - wdata = req_wdata
- With no grant, the register file is driven with we=0, addr0=0, addr1=0, wdata=0. A read with we=0 is non-destructive.
- Responses:
  - A granted read loads the response buffer with i_rf_data0 and i_rf_data1.
  - A granted write loads the response buffer with zeros, as a write acknowledgement.
  - In both cases o_rsp_valid_n is set.
- Response buffer:
  - o_rsp_valid_n clears on i_rsp_ready_n when there is no new grant to that requester in the same cycle.
  - The data is held stable while valid and not ready.
- Each requester has at most one outstanding response. It cannot be granted while its response is pending and unconsumed.

## Timing
- Grant, ready and register file drive all occur in the same cycle T as the accepted request.
- A write commits at the rising edge ending T. A read samples i_rf_data at that same edge.
- The response is visible from cycle T+1. Request-to-response latency is 1 cycle.
- Read-after-write:
  - A read granted at T+1 to an address written at T returns the new value.
  - A same-cycle write and read cannot occur, because grants are exclusive.
- Back-to-back throughput: with i_rsp_ready held high, one requester alone is granted every cycle.
- Under contention, with both valid and both ready, grants alternate 0,1,0,1 starting with the requester not granted last.
- Reset values: all o_rsp_valid = 0, all o_rsp_data = 0, o_req_ready = 0, o_rf_we = 0, o_rf_addr0/1 = 0, o_rf_wdata = 0, pointer = 1.
- Reset mid-operation: pending responses are discarded immediately (asynchronous). The requester must reissue.
- Valid dropped before ready: the request is treated as withdrawn and no access is performed. This is a protocol violation by the requester, and the arbiter does not flag it.

## Test plan
- Reset, then requester 0 writes addr 5 = 0xDEADBEEF:
  - ready_0 is high in the same cycle, o_rf_we=1, addr0=5.
  - Next cycle rsp_valid_0=1 with data0=0.
  - A read of (5,0) then returns data0=0xDEADBEEF, data1=0.
- Both requesters read continuously with rsp_ready high for 6 cycles: grant order is 0,1,0,1,0,1, and each rsp_valid asserts exactly one cycle after its grant.
- Requester 1 holds rsp_ready_1=0 for 4 cycles with valid_1 high:
  - ready_1 stays low and rsp_data stays constant.
  - Requester 0 is granted every cycle.
  - Requester 1 is granted in the cycle rsp_ready_1 rises.
- Requester 1 writes addr 3 = 0x12345678 at cycle T, and requester 0 reads (3,3) at T+1: response data0 = data1 = 0x12345678.
- Assert i_rst_n low while rsp_valid_0=1 and requester 1 is being granted:
  - All outputs go to reset values immediately.
  - After release, the first tie is granted to requester 0.
